// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands with same-cycle WB bypass,
// inserts load-use bubbles, and honours stall/flush. ID_EX_PERF_CNT_EN adds bubble/flush counters.
module id_ex_stage #(
    parameter int CTRL_W       = 12,
    parameter int MEM_READ_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_rd_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_rs1_data,
    output logic [31:0]       ex_rs2_data,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic        wb_live;
    logic [31:0] rs1_byp;
    logic [31:0] rs2_byp;
    logic        hazard;

    // Stage protocol: ex_valid marks a real entry; stall_in freezes it, flush
    // squashes it, and load_use_stall asks upstream to hold ID for one cycle.
    always_comb begin
        wb_live = wb_reg_write && (wb_rd != 5'd0);
        rs1_byp = (wb_live && wb_rd == id_rs1) ? wb_rd_data : id_rs1_data;
        rs2_byp = (wb_live && wb_rd == id_rs2) ? wb_rd_data : id_rs2_data;
        hazard  = id_valid && ex_valid && ex_ctrl[MEM_READ_BIT] && (ex_rd != 5'd0) &&
                  ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        load_use_stall = hazard && !flush && !stall_in;
    end

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall_in && load_use_stall)) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_ctrl     <= '0;
        end else if (stall_in) begin
            // A held entry keeps tracking WB so its operands are not stale on release.
            if (ex_valid && wb_live && wb_rd == ex_rs1) ex_rs1_data <= wb_rd_data;
            if (ex_valid && wb_live && wb_rd == ex_rs2) ex_rs2_data <= wb_rd_data;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_rs1_data <= rs1_byp;
            ex_rs2_data <= rs2_byp;
            ex_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (load_use_stall) bubble_cnt <= bubble_cnt + 32'd1;
            if (flush)          flush_cnt  <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hand-written multi-cycle sequences.
module tb_id_ex_stage;
    localparam int W = 156;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [11:0] id_ctrl;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_data;
    logic        stall_in, flush;
    logic        load_use_stall, ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [11:0] ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    id_ex_stage #(.CTRL_W(12), .MEM_READ_BIT(0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_ctrl(id_ctrl), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_rd_data(wb_rd_data),
        .stall_in(stall_in), .flush(flush), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2;
        logic [11:0] ctrl;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        e_valid;
        logic [31:0] e_d1, e_d2;
        logic [11:0] e_ctrl;
    } vec_t;

    function automatic logic [W-1:0] pack(logic v, logic [31:0] pc, logic [31:0] imm,
                                          logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                                          logic [31:0] d1, logic [31:0] d2, logic [11:0] c);
        return {v, pc, imm, r1, r2, rd, d1, d2, c};
    endfunction

    function automatic logic [W-1:0] dut_bundle();
        return pack(ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_ctrl);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic idle();
        id_valid = 0; id_pc = 0; id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_ctrl = 0;
        wb_reg_write = 0; wb_rd = 0; wb_rd_data = 0; stall_in = 0; flush = 0;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [11:0] c);
        id_valid = v; id_pc = pc; id_imm = imm; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2; id_ctrl = c;
    endtask

    task automatic randomize_id();
        set_id(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom, $urandom, 12'($urandom_range(0, 4095)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard pop
    task automatic sb_check(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got empty expected queue required an entry", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, dut_bundle(), e);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 32'h100, 32'h4, 3, 4, 1, 32'h11, 32'h22, 12'h0F0, 0, 0, 0, 1, 32'h11, 32'h22, 12'h0F0};
        vecs[1] = '{1, 32'h104, 32'h8, 5, 6, 2, 32'hAAAA, 32'hBBBB, 12'h0A2, 1, 5, 32'h1234, 1, 32'h1234, 32'hBBBB, 12'h0A2};
        vecs[2] = '{1, 32'h108, 32'hC, 0, 0, 3, 32'h0, 32'h0, 12'h002, 1, 0, 32'hDEAD, 1, 32'h0, 32'h0, 12'h002};
        vecs[3] = '{1, 32'h10C, 32'h10, 8, 9, 4, 32'h8, 32'h9, 12'h100, 1, 9, 32'h999, 1, 32'h8, 32'h999, 12'h100};
        vecs[4] = '{1, 32'h110, 32'h14, 8, 2, 6, 32'h80, 32'h2, 12'h200, 0, 8, 32'hFFFF, 1, 32'h80, 32'h2, 12'h200};
        vecs[5] = '{0, 32'h114, 32'h18, 1, 2, 7, 32'h1, 32'h2, 12'hABE, 0, 0, 0, 0, 32'h1, 32'h2, 12'h000};
        vecs[6] = '{1, 32'h118, 32'h1C, 10, 10, 11, 32'hA, 32'hA, 12'h040, 1, 10, 32'h7777, 1, 32'h7777, 32'h7777, 12'h040};

        // reset with random ID traffic
        idle();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            randomize_id();
            tick();
            chk("reset_ex", dut_bundle(), '0);
            chk("reset_lus", W'(load_use_stall), '0);
        end
        @(negedge clk);
        rst = 0;
        idle();

        // vector table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            idle();
            set_id(vecs[i].valid, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   1, 1, vecs[i].d1, vecs[i].d2, vecs[i].ctrl);
            wb_reg_write = vecs[i].wbw; wb_rd = vecs[i].wbrd; wb_rd_data = vecs[i].wbd;
            #1;
            chk("vec_lus", W'(load_use_stall), '0);
            exp_q.push_back(pack(vecs[i].e_valid, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2,
                                 vecs[i].rd, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_ctrl));
            tick();
            sb_check($sformatf("vec%0d", i));
        end

        // load-use: one bubble, then capture with WB bypass
        @(negedge clk);
        idle();
        set_id(1, 32'h300, 0, 1, 0, 7, 0, 0, 32'h1, 0, 12'h001);
        exp_q.push_back(pack(1, 32'h300, 0, 1, 0, 7, 32'h1, 0, 12'h001));
        tick();
        sb_check("lu_load");
        @(negedge clk);
        set_id(1, 32'h304, 32'h10, 2, 7, 8, 1, 1, 32'h2, 32'h0, 12'h004);
        #1;
        chk("lu_stall_hi", W'(load_use_stall), W'(1));
        tick();
        chk("lu_bubble", W'({ex_valid, ex_ctrl}), '0);
        @(negedge clk);
        wb_reg_write = 1; wb_rd = 7; wb_rd_data = 32'hCAFE;
        #1;
        chk("lu_one_bubble", W'(load_use_stall), '0);
        exp_q.push_back(pack(1, 32'h304, 32'h10, 2, 7, 8, 32'h2, 32'hCAFE, 12'h004));
        tick();
        sb_check("lu_bypass");
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt", W'(bubble_cnt), W'(1));
`endif

        // stall with WB refresh of a held entry
        @(negedge clk);
        idle();
        set_id(1, 32'h200, 32'h20, 9, 4, 5, 1, 1, 32'h90, 32'h44, 12'h010);
        exp_q.push_back(pack(1, 32'h200, 32'h20, 9, 4, 5, 32'h90, 32'h44, 12'h010));
        tick();
        sb_check("st_load");
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            idle();
            randomize_id();
            stall_in = 1;
            if (c == 2) begin
                wb_reg_write = 1; wb_rd = 9; wb_rd_data = 32'h55;
            end
            exp_q.push_back(pack(1, 32'h200, 32'h20, 9, 4, 5, (c >= 2) ? 32'h55 : 32'h90, 32'h44, 12'h010));
            tick();
            sb_check($sformatf("st_hold%0d", c));
        end

        // flush beats stall and load-use
        @(negedge clk);
        idle();
        set_id(1, 32'h400, 0, 0, 0, 7, 0, 0, 0, 0, 12'h001);
        exp_q.push_back(pack(1, 32'h400, 0, 0, 0, 7, 0, 0, 12'h001));
        tick();
        sb_check("fl_load");
        @(negedge clk);
        set_id(1, 32'h404, 0, 3, 7, 9, 1, 1, 32'h3, 32'h7, 12'h008);
        stall_in = 1; flush = 1;
        #1;
        chk("fl_lus", W'(load_use_stall), '0);
        exp_q.push_back('0);
        tick();
        sb_check("fl_squash");
`ifdef ID_EX_PERF_CNT_EN
        chk("flush_cnt", W'(flush_cnt), W'(1));
`endif

        // reset during a load-use stall
        @(negedge clk);
        idle();
        set_id(1, 32'h500, 0, 0, 0, 7, 0, 0, 0, 0, 12'h001);
        exp_q.push_back(pack(1, 32'h500, 0, 0, 0, 7, 0, 0, 12'h001));
        tick();
        sb_check("rs_load");
        @(negedge clk);
        set_id(1, 32'h504, 0, 7, 0, 9, 1, 0, 32'h7, 0, 12'h008);
        #1;
        chk("rs_lus_pre", W'(load_use_stall), W'(1));
        rst = 1;
        tick();
        chk("rs_zero", dut_bundle(), '0);
        chk("rs_lus_post", W'(load_use_stall), '0);
`ifdef ID_EX_PERF_CNT_EN
        chk("rs_cnts", W'({bubble_cnt, flush_cnt}), '0);
`endif
        @(negedge clk);
        rst = 0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
